// File: rtl/kinematics_seq_pkg.sv
// Shared types and stage indices for the inverse-kinematics sequencer.
package kinematics_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_PREP,
    SEQ_RUN,
    SEQ_FAULT
  } seq_state_t;

  localparam int STG_FK   = 0;
  localparam int STG_J    = 1;
  localparam int STG_JI   = 2;
  localparam int STG_MULT = 3;
  localparam int STG_CONV = 4;

endpackage

// File: rtl/kinematics_sequencer_stage_watchdog.sv
// Per-stage watchdog: counts RUN cycles and flags the last allowed cycle.
module stage_watchdog #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 count_en,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  // A zero limit disables the watchdog; wrap-around of count is harmless then.
  assign expired = (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/kinematics_sequencer.sv
// Sequences NUM_STAGES compute blocks in order through reset/enable/done,
// with start/abort, continuous mode, per-stage watchdog and a pass counter.
module kinematics_sequencer
  import kinematics_seq_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int TIMEOUT_W  = 16,
  parameter int ITER_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          continuous,
  input  logic [TIMEOUT_W-1:0]          timeout_cycles,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic [NUM_STAGES-1:0]         stage_enable,
  output logic [NUM_STAGES-1:0]         stage_reset,
  output logic                          busy,
  output logic                          cycle_done,
  output logic                          error,
  output logic [$clog2(NUM_STAGES)-1:0] error_stage,
  output logic [$clog2(NUM_STAGES)-1:0] current_stage,
  output logic [ITER_W-1:0]             iter_count
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [SW-1:0] FIRST = SW'(STG_FK);
  localparam logic [SW-1:0] LAST  = SW'(NUM_STAGES - 1);

  // Stage handshake: a stage sees one PREP cycle in reset, then runs with
  // enable=1/reset=0 until it raises done; done is sampled only from the
  // active stage and drops its enable on the following cycle.
  seq_state_t           state;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic                 wd_expired;

  function automatic logic [NUM_STAGES-1:0] onehot(input logic [SW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  stage_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == SEQ_PREP),
    .count_en (state == SEQ_RUN),
    .limit    (timeout_q),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SEQ_IDLE;
      stage_enable  <= '0;
      stage_reset   <= '1;
      busy          <= 1'b0;
      cycle_done    <= 1'b0;
      error         <= 1'b0;
      error_stage   <= '0;
      current_stage <= '0;
      iter_count    <= '0;
      timeout_q     <= '0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        SEQ_IDLE: begin
          if (start && !abort) begin
            state         <= SEQ_PREP;
            current_stage <= FIRST;
            timeout_q     <= timeout_cycles;
            busy          <= 1'b1;
          end
        end
        SEQ_PREP: begin
          if (abort) begin
            state         <= SEQ_IDLE;
            busy          <= 1'b0;
            current_stage <= FIRST;
          end else begin
            state        <= SEQ_RUN;
            stage_enable <= onehot(current_stage);
            stage_reset  <= ~onehot(current_stage);
          end
        end
        SEQ_RUN: begin
          if (abort) begin
            state         <= SEQ_IDLE;
            busy          <= 1'b0;
            current_stage <= FIRST;
            stage_enable  <= '0;
            stage_reset   <= '1;
          end else if (stage_done[current_stage]) begin
            stage_enable <= '0;
            stage_reset  <= '1;
            if (current_stage == LAST) begin
              cycle_done    <= 1'b1;
              iter_count    <= iter_count + 1'b1;
              current_stage <= FIRST;
              if (continuous) begin
                state <= SEQ_PREP;
              end else begin
                state <= SEQ_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              state         <= SEQ_PREP;
              current_stage <= current_stage + 1'b1;
            end
          end else if (wd_expired) begin
            state        <= SEQ_FAULT;
            error        <= 1'b1;
            error_stage  <= current_stage;
            busy         <= 1'b0;
            stage_enable <= '0;
            stage_reset  <= '1;
          end
        end
        SEQ_FAULT: begin
          if (abort) begin
            state <= SEQ_IDLE;
            error <= 1'b0;
          end else if (start) begin
            state         <= SEQ_PREP;
            error         <= 1'b0;
            current_stage <= FIRST;
            timeout_q     <= timeout_cycles;
            busy          <= 1'b1;
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kinematics_sequencer.sv
// Directed bench for kinematics_sequencer; a second instance with ITER_W=2
// shares the stimulus to exercise pass-counter wrap.
module tb_kinematics_sequencer;

  localparam int NS = 5;

  logic        clk = 1'b0;
  logic        reset, start, abort, continuous;
  logic [15:0] timeout_cycles;
  logic [4:0]  stage_done;

  logic [4:0]  stage_enable, stage_reset;
  logic        busy, cycle_done, error;
  logic [2:0]  error_stage, current_stage;
  logic [15:0] iter_count;

  logic [4:0]  s_stage_enable, s_stage_reset;
  logic        s_busy, s_cycle_done, s_error;
  logic [2:0]  s_error_stage, s_current_stage;
  logic [1:0]  s_iter_count;

  int n_checks = 0;
  int n_fail   = 0;

  int dly [NS];
  int run_cnt = 0;

  int en_cycles [NS];
  int cd_at [4];
  int cd_pulses, order_err, n_cycles, first_en, drop_after;

  always #5 clk = ~clk;

  kinematics_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .continuous(continuous), .timeout_cycles(timeout_cycles),
    .stage_done(stage_done), .stage_enable(stage_enable),
    .stage_reset(stage_reset), .busy(busy), .cycle_done(cycle_done),
    .error(error), .error_stage(error_stage),
    .current_stage(current_stage), .iter_count(iter_count)
  );

  kinematics_sequencer #(.ITER_W(2)) u_small (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .continuous(continuous), .timeout_cycles(timeout_cycles),
    .stage_done(stage_done), .stage_enable(s_stage_enable),
    .stage_reset(s_stage_reset), .busy(s_busy), .cycle_done(s_cycle_done),
    .error(s_error), .error_stage(s_error_stage),
    .current_stage(s_current_stage), .iter_count(s_iter_count)
  );

  // Stage model: raises done on the dly[k]-th enabled cycle; dly[k]=0 stalls.
  always @(posedge clk) begin
    #2;
    stage_done = '0;
    if (stage_enable == '0) begin
      run_cnt = 0;
    end else begin
      run_cnt++;
      for (int k = 0; k < NS; k++)
        if (stage_enable[k] && dly[k] != 0 && run_cnt == dly[k]) stage_done[k] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dly(input int d);
    for (int k = 0; k < NS; k++) dly[k] = d;
  endtask

  // Runs until busy drops, collecting per-stage enable counts and pulses.
  task automatic run_watch(input int budget);
    int last, idx;
    bit ended;
    last = -1; ended = 0;
    cd_pulses = 0; order_err = 0; n_cycles = 0; first_en = 0;
    for (int k = 0; k < NS; k++) en_cycles[k] = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      n_cycles++;
      start = 1'b0;
      if (cycle_done) begin
        if (cd_pulses < 4) cd_at[cd_pulses] = n_cycles;
        cd_pulses++;
        if (drop_after != 0 && cd_pulses == drop_after) continuous = 1'b0;
      end
      if (stage_enable != '0) begin
        idx = 0;
        for (int k = 0; k < NS; k++) if (stage_enable[k]) idx = k;
        if (stage_enable[0] && first_en == 0) first_en = n_cycles;
        en_cycles[idx]++;
        if (idx != last) begin
          if (idx != (last + 1) % NS) order_err++;
          last = idx;
        end
      end
      if (!busy) begin
        ended = 1;
        break;
      end
    end
    check("watch_bound", 32'(ended), 32'd1);
  endtask

  task automatic wait_enable(input logic [4:0] target, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      start = 1'b0;
      if (stage_enable == target) begin
        seen = 1;
        break;
      end
    end
    check("wait_enable_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    timeout_cycles = 16'd0; stage_done = '0; drop_after = 0;
    set_dly(1);
    tick(); tick();
    reset = 1'b0;
    tick();

    check("rst_enable", stage_enable, 5'h00);
    check("rst_stage_reset", stage_reset, 5'h1f);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_iter", iter_count, 16'd0);

    // Five short passes: small counter wraps 3 -> 0 -> 1.
    timeout_cycles = 16'd100;
    for (int p = 0; p < 5; p++) begin
      start = 1'b1;
      run_watch(40);
    end
    check("wrap_iter_big", iter_count, 16'd5);
    check("wrap_iter_small", s_iter_count, 2'd1);

    // Nominal pass, 3-cycle dones.
    set_dly(3);
    start = 1'b1;
    run_watch(60);
    check("nom_first_en", first_en, 2);
    for (int k = 0; k < NS; k++) check($sformatf("nom_en_cycles%0d", k), en_cycles[k], 3);
    check("nom_order", order_err, 0);
    check("nom_cd_pulses", cd_pulses, 1);
    check("nom_cd_at", cd_at[0], 21);
    check("nom_iter", iter_count, 16'd6);
    check("nom_busy", busy, 1'b0);
    check("nom_stage_reset", stage_reset, 5'h1f);

    // Continuous mode, dropped during the third pass.
    set_dly(1);
    continuous = 1'b1; drop_after = 2;
    start = 1'b1;
    run_watch(100);
    drop_after = 0;
    check("cont_pulses", cd_pulses, 3);
    check("cont_cd0", cd_at[0], 11);
    check("cont_cd1", cd_at[1], 21);
    check("cont_cd2", cd_at[2], 31);
    check("cont_order", order_err, 0);
    check("cont_iter", iter_count, 16'd9);

    // Watchdog on stage 2.
    set_dly(3); dly[2] = 0;
    timeout_cycles = 16'd10;
    start = 1'b1;
    run_watch(80);
    check("wd_en2_cycles", en_cycles[2], 10);
    check("wd_error", error, 1'b1);
    check("wd_error_stage", error_stage, 3'd2);
    check("wd_cd_pulses", cd_pulses, 0);
    check("wd_stage_reset", stage_reset, 5'h1f);
    check("wd_iter", iter_count, 16'd9);
    set_dly(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wd_restart_error", error, 1'b0);
    check("wd_restart_busy", busy, 1'b1);
    check("wd_restart_stage", current_stage, 3'd0);
    tick();
    check("wd_restart_en", stage_enable, 5'h01);
    run_watch(60);
    check("wd_restart_cd", cd_pulses, 1);
    check("wd_restart_iter", iter_count, 16'd10);

    // Done on the timeout cycle counts as success.
    set_dly(10);
    start = 1'b1;
    run_watch(80);
    check("edge_error", error, 1'b0);
    check("edge_cd", cd_pulses, 1);
    check("edge_en4_cycles", en_cycles[4], 10);
    check("edge_iter", iter_count, 16'd11);

    // Start while busy is ignored.
    set_dly(3);
    timeout_cycles = 16'd100;
    start = 1'b1;
    wait_enable(5'h02, 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_en", stage_enable, 5'h02);
    check("busy_start_stage", current_stage, 3'd1);
    run_watch(60);
    check("busy_start_cd", cd_pulses, 1);
    check("busy_start_iter", iter_count, 16'd12);

    // Abort during stage 3.
    start = 1'b1;
    wait_enable(5'h08, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_stage_reset", stage_reset, 5'h1f);
    check("abort_en", stage_enable, 5'h00);
    check("abort_cd", cycle_done, 1'b0);
    cd_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cycle_done) cd_pulses++;
    end
    check("abort_no_cd", cd_pulses, 0);
    check("abort_iter", iter_count, 16'd12);

    // Watchdog disabled across a 70000-cycle stall (counter wraps).
    timeout_cycles = 16'd0;
    set_dly(1); dly[0] = 70000;
    start = 1'b1;
    run_watch(80000);
    check("nowd_error", error, 1'b0);
    check("nowd_cd", cd_pulses, 1);
    check("nowd_en0_cycles", en_cycles[0], 70000);
    check("nowd_iter", iter_count, 16'd13);
    check("nowd_iter_small", s_iter_count, 2'd1);

    // Reset during stage 1.
    set_dly(3);
    timeout_cycles = 16'd100;
    start = 1'b1;
    wait_enable(5'h02, 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_enable", stage_enable, 5'h00);
    check("mrst_stage_reset", stage_reset, 5'h1f);
    check("mrst_busy", busy, 1'b0);
    check("mrst_cd", cycle_done, 1'b0);
    check("mrst_error", error, 1'b0);
    check("mrst_error_stage", error_stage, 3'd0);
    check("mrst_current_stage", current_stage, 3'd0);
    check("mrst_iter", iter_count, 16'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
